// File: rtl/bus_rr.sv
// bus_rr: round-robin arbiter for NrHosts onto base/mask-decoded devices, with an
// in-order FIFO that routes each response back to the host that issued it.
module bus_rr #(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 4,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic [NrDevices-1:0]      device_req_o,
  output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]      device_rvalid_i,
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]      device_err_i,
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);
  localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int TgtW  = $clog2(NrDevices + 1);
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [TgtW-1:0] Unmapped = TgtW'(NrDevices);

  logic [HostW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TgtW-1:0]  last_tgt_q, last_tgt_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [HostW-1:0] fifo_host_q [MaxOutstanding];
  logic [TgtW-1:0]  fifo_tgt_q [MaxOutstanding];

  logic                 cand_valid, gnt, pop, fifo_empty, fifo_full;
  logic [HostW-1:0]     cand_host, head_host;
  logic [TgtW-1:0]      cand_tgt, head_tgt;
  logic                 head_rvalid, head_err;
  logic [DataWidth-1:0] head_rdata;
  logic [NrDevices-1:0] head_onehot;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign head_host  = fifo_host_q[rd_ptr_q];
  assign head_tgt   = fifo_tgt_q[rd_ptr_q];

  // Two passes: hosts after the last winner first, then the wrap-around part.
  always_comb begin
    cand_valid = 1'b0;
    cand_host  = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (!cand_valid && host_req_i[h] && h > int'(rr_ptr_q)) begin
        cand_valid = 1'b1;
        cand_host  = HostW'(h);
      end
    end
    for (int h = 0; h < NrHosts; h++) begin
      if (!cand_valid && host_req_i[h] && h <= int'(rr_ptr_q)) begin
        cand_valid = 1'b1;
        cand_host  = HostW'(h);
      end
    end
  end

  always_comb begin
    cand_tgt = Unmapped;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((host_addr_i[cand_host] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        cand_tgt = TgtW'(d);
      end
    end
  end

  // Unmapped entries complete on their own as soon as they reach the head.
  always_comb begin
    head_rvalid = (head_tgt == Unmapped);
    head_err    = (head_tgt == Unmapped);
    head_rdata  = '0;
    head_onehot = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (head_tgt == TgtW'(d)) begin
        head_rvalid    = device_rvalid_i[d];
        head_err       = device_err_i[d];
        head_rdata     = device_rdata_i[d];
        head_onehot[d] = 1'b1;
      end
    end
  end

  assign pop = !rst_i && !fifo_empty && head_rvalid;
  // A new target must wait for the FIFO to drain so responses stay in order.
  assign gnt = !rst_i && cand_valid && (!fifo_full || pop) &&
               (fifo_empty || cand_tgt == last_tgt_q);

  always_comb begin
    host_gnt_o   = '0;
    device_req_o = '0;
    device_we_o  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      device_addr_o[d]  = '0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
    end
    if (gnt) begin
      host_gnt_o[cand_host] = 1'b1;
      for (int d = 0; d < NrDevices; d++) begin
        if (cand_tgt == TgtW'(d)) begin
          device_req_o[d]   = 1'b1;
          device_addr_o[d]  = host_addr_i[cand_host];
          device_we_o[d]    = host_we_i[cand_host];
          device_be_o[d]    = host_be_i[cand_host];
          device_wdata_o[d] = host_wdata_i[cand_host];
        end
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      host_rdata_o[h] = '0;
      if (pop && head_host == HostW'(h)) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = head_err;
        host_rdata_o[h]  = head_rdata;
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    last_tgt_d = last_tgt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (gnt) begin
      rr_ptr_d   = cand_host;
      last_tgt_d = cand_tgt;
      wr_ptr_d   = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (gnt && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!gnt && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= HostW'(NrHosts - 1);
      last_tgt_q <= Unmapped;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      last_tgt_q <= last_tgt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) begin
      fifo_host_q[wr_ptr_q] <= cand_host;
      fifo_tgt_q[wr_ptr_q]  <= cand_tgt;
    end
  end

  // Only the device at the head of the FIFO may return a response.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !fifo_empty |-> ((device_rvalid_i & ~head_onehot) == '0));

endmodule

// File: doc/bus_rr.md
Name: bus_rr

Overview:
Parametrised multi-host system interconnect, successor to the single-host decoded bus. It arbitrates N hosts (core data port, DMA, debug) round-robin onto one shared request path, and decodes the granted address against per-device base/mask registers. It tracks up to MaxOutstanding in-flight transactions and routes each response back to the host that issued it. Unmapped addresses are completed internally with an error response.

Parameters:
NrHosts, 2, number of host ports (>=1)
NrDevices, 4, number of device ports (>=1)
DataWidth, 32, data bus width
AddressWidth, 32, address bus width
MaxOutstanding, 2, depth of in-flight tracking FIFO (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active high
host_req_i  in  1 [NrHosts]  host request
host_gnt_o  out  1 [NrHosts]  request accepted this cycle
host_addr_i  in  AddressWidth [NrHosts]  byte address
host_we_i  in  1 [NrHosts]  write enable
host_be_i  in  DataWidth/8 [NrHosts]  byte enables
host_wdata_i  in  DataWidth [NrHosts]  write data
host_rvalid_o  out  1 [NrHosts]  response valid
host_rdata_o  out  DataWidth [NrHosts]  read data
host_err_o  out  1 [NrHosts]  response error, qualified by rvalid
device_req_o  out  1 [NrDevices]  device request
device_addr_o  out  AddressWidth [NrDevices]  address
device_we_o  out  1 [NrDevices]  write enable
device_be_o  out  DataWidth/8 [NrDevices]  byte enables
device_wdata_o  out  DataWidth [NrDevices]  write data
device_rvalid_i  in  1 [NrDevices]  device response valid
device_rdata_i  in  DataWidth [NrDevices]  device read data
device_err_i  in  1 [NrDevices]  device error
cfg_device_addr_base  in  AddressWidth [NrDevices]  device base address
cfg_device_addr_mask  in  AddressWidth [NrDevices]  device address mask

Behaviour:
- Reset (rst_i high, async): FIFO empty. RR pointer = NrHosts-1, so host 0 has first priority. All host_gnt_o/host_rvalid_o/host_err_o/device_req_o = 0. All data outputs = 0.
- Decode: the granted address hits device d if (addr & mask[d]) == base[d]. On overlap, the lowest d wins. No hit means target = unmapped, encoded internally as index NrDevices.
- Arbitration: combinational and single-cycle. Search starts at the host after the last granted host, wrapping modulo NrHosts. The first requesting host is the candidate. The RR pointer updates only on an actual grant.
- Grant condition, evaluated for the candidate:
  - FIFO not full, or a pop occurs in the same cycle; AND
  - FIFO empty, or candidate target == target of the most recently pushed entry.
  - Ordering rule: a host whose target differs is stalled (no gnt) until the FIFO drains, so responses can never reorder.
  - The stalled candidate keeps priority. Lower-priority hosts are not granted around it.
- On grant:
  - host_gnt_o[h] = 1 in the same cycle.
  - If mapped, device_req_o[d] = 1 with addr/we/be/wdata from host h.
  - Push {h, target} into the FIFO.
  - Non-selected device outputs are 0.
- Response, FIFO head {h, t}:
  - Mapped t: when device_rvalid_i[t] = 1, drive host_rvalid_o[h] = 1, host_rdata_o[h] = device_rdata_i[t], host_err_o[h] = device_err_i[t], and pop. Same cycle, no added latency.
  - Unmapped t: respond whenever the entry is at head, earliest the cycle after grant. Drive rvalid = 1, err = 1, rdata = 0, and pop. This gives one unmapped response per cycle.
  - device_rvalid_i from a device other than the head target is ignored (protocol violation; flagged by an assertion).
- Push and pop in the same cycle are legal at any fill level, including full.
- FIFO pointers wrap modulo MaxOutstanding. Count width is $clog2(MaxOutstanding+1).
- Reset mid-transaction: the FIFO is flushed. A late device rvalid after reset is dropped.
- Hosts must hold req/addr/wdata stable until gnt.

Test Plan:
- Single host, RAM at base 0x100000, mask ~0x1FFF. Read 0x100004; device rvalid 1 cycle later with 0xDEADBEEF -> gnt same cycle, host rvalid cycle+1, rdata 0xDEADBEEF, err 0.
- Two hosts requesting continuously, same device -> grants alternate 0,1,0,1. Each host receives only its own responses, in order.
- Host 0 reads 0x0 (unmapped) -> gnt, next cycle rvalid = 1, err = 1, rdata = 0. No device_req asserted.
- MaxOutstanding = 2, device withholds rvalid for 5 cycles -> two grants, then gnt held low. The third request is granted in the same cycle the first rvalid pops.
- Host 0 in flight to GPIO, host 1 requests Timer -> host 1 stalled until GPIO rvalid drains the FIFO, granted in the following cycle.
- Assert rst_i mid-transaction with one entry outstanding -> all outputs 0 immediately. A subsequent device rvalid produces no host rvalid.
